// File: rtl/sequ_pkg.sv
// Shared definitions for the serial sequence generator and its matching detector.
package sequ_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Pattern the sequence detector flags; keep in step with the detector side.
  localparam logic [7:0] SEQU_DEFAULT_PAT = 8'b1110_1000;

endpackage

// File: rtl/sequ_piso.sv
// Parallel-in serial-out shift register, MSB first, with load priority over shift.
module sequ_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sreg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
    end else if (load_i) begin
      sreg_q <= din_i;
    end else if (shift_i) begin
      sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb_o = sreg_q[WIDTH-1];

endmodule

// File: rtl/sequ_gen.sv
// Serial pattern generator: sends a WIDTH-bit pattern MSB-first, repeated with idle gaps.
module sequ_gen
  import sequ_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] DEFAULT_PAT = WIDTH'(SEQU_DEFAULT_PAT),
  parameter int               REPEAT_W    = 4,
  parameter int               GAP_LEN     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                use_default,
  input  logic [WIDTH-1:0]    pattern_in,
  input  logic [REPEAT_W-1:0] repeat_cnt,
  input  logic                abort,
  output logic                data_out,
  output logic                bit_valid,
  output logic                busy,
  output logic                done
);

  localparam int IDXW = $clog2(WIDTH);
  localparam int GAPW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  state_e              state_q;
  logic [WIDTH-1:0]    pat_q;
  logic [REPEAT_W-1:0] rep_q;
  logic [IDXW-1:0]     idx_q;
  logic [GAPW-1:0]     gap_q;
  logic                data_out_q, bit_valid_q, busy_q, done_q;

  logic             start_ok, last_bit, more_reps;
  logic [WIDTH-1:0] pat_sel;
  logic             piso_load, piso_shift, piso_msb;
  logic [WIDTH-1:0] piso_din;

  // The data_out register holds the current bit; the PISO holds the bits still to come.
  always_comb begin
    pat_sel    = use_default ? DEFAULT_PAT : pattern_in;
    start_ok   = (state_q == IDLE) && start && !abort;
    last_bit   = (state_q == SHIFT) && (idx_q == '0);
    more_reps  = (rep_q > REPEAT_W'(1));
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    piso_din   = {pat_q[WIDTH-2:0], 1'b0};
    if (start_ok) begin
      piso_load = 1'b1;
      piso_din  = {pat_sel[WIDTH-2:0], 1'b0};
    end else if (!abort) begin
      if ((state_q == SHIFT) && !last_bit) piso_shift = 1'b1;
      if (last_bit && more_reps && (GAP_LEN == 0)) piso_load = 1'b1;
      if ((state_q == GAP) && (gap_q == '0)) piso_load = 1'b1;
    end
  end

  sequ_piso #(.WIDTH(WIDTH)) u_piso (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (piso_load),
    .shift_i(piso_shift),
    .din_i  (piso_din),
    .msb_o  (piso_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      rep_q       <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      data_out_q  <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_ok) begin
            pat_q       <= pat_sel;
            rep_q       <= (repeat_cnt == '0) ? REPEAT_W'(1) : repeat_cnt;
            idx_q       <= IDXW'(WIDTH - 1);
            state_q     <= SHIFT;
            data_out_q  <= pat_sel[WIDTH-1];
            bit_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        SHIFT: begin
          if (abort) begin
            state_q     <= IDLE;
            data_out_q  <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (!last_bit) begin
            data_out_q <= piso_msb;
            idx_q      <= idx_q - 1'b1;
          end else if (more_reps) begin
            rep_q <= rep_q - 1'b1;
            if (GAP_LEN == 0) begin
              data_out_q <= pat_q[WIDTH-1];
              idx_q      <= IDXW'(WIDTH - 1);
            end else begin
              state_q     <= GAP;
              gap_q       <= GAPW'(GAP_LEN - 1);
              data_out_q  <= 1'b0;
              bit_valid_q <= 1'b0;
            end
          end else begin
            state_q     <= IDLE;
            data_out_q  <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        GAP: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (gap_q == '0) begin
            state_q     <= SHIFT;
            idx_q       <= IDXW'(WIDTH - 1);
            data_out_q  <= pat_q[WIDTH-1];
            bit_valid_q <= 1'b1;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sequ_gen.sv
// Randomized bench for sequ_gen (gap 2 and gap 0 instances) against a queue-based model.
module tb_sequ_gen;

  logic       clk, rst_n;
  logic       start, use_default, abort;
  logic [7:0] pattern_in;
  logic [3:0] repeat_cnt;
  logic       d2, v2, b2, dn2;
  logic       d0, v0, b0, dn0;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected per-cycle items, packed {data_out, bit_valid, busy, done}.
  logic [3:0] q2[$], q0[$], tmp[$];
  logic       busy2_m, busy0_m;
  logic [7:0] hist;
  int         hits;

  sequ_gen #(.WIDTH(8), .REPEAT_W(4), .GAP_LEN(2)) dut_g2 (
    .clk(clk), .rst_n(rst_n), .start(start), .use_default(use_default),
    .pattern_in(pattern_in), .repeat_cnt(repeat_cnt), .abort(abort),
    .data_out(d2), .bit_valid(v2), .busy(b2), .done(dn2)
  );

  sequ_gen #(.WIDTH(8), .REPEAT_W(4), .GAP_LEN(0)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .start(start), .use_default(use_default),
    .pattern_in(pattern_in), .repeat_cnt(repeat_cnt), .abort(abort),
    .data_out(d0), .bit_valid(v0), .busy(b0), .done(dn0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, act, exp);
    end
  endtask

  // Whole transfer as seen on the outputs, starting the cycle after acceptance.
  task automatic build(input logic [7:0] p, input int r, input int gap);
    tmp.delete();
    for (int i = 0; i < r; i++) begin
      for (int k = 7; k >= 0; k--) tmp.push_back({p[k], 3'b110});
      if (i < r - 1) for (int g = 0; g < gap; g++) tmp.push_back(4'b0010);
    end
    tmp.push_back(4'b0001);
  endtask

  task automatic cycle();
    logic [7:0] sel;
    int         r;
    logic [3:0] e2, e0;
    sel = use_default ? 8'b1110_1000 : pattern_in;
    r   = (repeat_cnt == 0) ? 1 : int'(repeat_cnt);
    if (abort) begin
      if (busy2_m) q2.delete();
      if (busy0_m) q0.delete();
    end else if (start) begin
      if (!busy2_m) begin build(sel, r, 2); q2 = tmp; end
      if (!busy0_m) begin build(sel, r, 0); q0 = tmp; end
    end
    @(posedge clk);
    @(negedge clk);
    e2 = (q2.size() > 0) ? q2.pop_front() : 4'b0000;
    e0 = (q0.size() > 0) ? q0.pop_front() : 4'b0000;
    chk("gap2_outs", {28'd0, d2, v2, b2, dn2}, {28'd0, e2});
    chk("gap0_outs", {28'd0, d0, v0, b0, dn0}, {28'd0, e0});
    busy2_m = e2[1];
    busy0_m = e0[1];
    hist = {hist[6:0], d2};
    if (v2 && hist == 8'b1110_1000) hits++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic kick(input logic dflt, input logic [7:0] p, input logic [3:0] r);
    use_default = dflt; pattern_in = p; repeat_cnt = r; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; use_default = 1'b0; abort = 1'b0;
    pattern_in = 8'h00; repeat_cnt = 4'd0;
    busy2_m = 1'b0; busy0_m = 1'b0; hist = 8'h00; hits = 0;
    repeat (3) @(negedge clk);
    chk("reset_g2", {28'd0, d2, v2, b2, dn2}, 32'd0);
    chk("reset_g0", {28'd0, d0, v0, b0, dn0}, 32'd0);
    rst_n = 1'b1;
    run(2);

    kick(1'b1, 8'h00, 4'd1);             // default pattern once
    run(10);
    kick(1'b0, 8'hA5, 4'd3);             // user pattern, three repeats
    run(30);
    kick(1'b0, 8'h3C, 4'd0);             // zero repeats behaves as one
    run(3);
    start = 1'b1; pattern_in = 8'hFF; repeat_cnt = 4'd5;
    cycle();
    start = 1'b0;
    run(8);

    kick(1'b1, 8'h00, 4'd3);             // abort inside the second repetition
    run(12);
    abort = 1'b1; cycle(); abort = 1'b0;
    run(1);
    kick(1'b1, 8'h00, 4'd1);
    run(12);
    abort = 1'b1; start = 1'b1; cycle();  // abort beats start in IDLE
    abort = 1'b0; start = 1'b0;
    run(2);

    use_default = 1'b0; pattern_in = 8'h96; repeat_cnt = 4'd1; start = 1'b1;
    run(25);                             // start held through done cycles
    start = 1'b0;
    run(12);

    kick(1'b0, 8'hC3, 4'd2);             // asynchronous reset mid-shift
    run(5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_g2", {28'd0, d2, v2, b2, dn2}, 32'd0);
    chk("async_rst_g0", {28'd0, d0, v0, b0, dn0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    q2.delete(); q0.delete(); busy2_m = 1'b0; busy0_m = 1'b0;
    run(2);

    hist = 8'h00; hits = 0;              // loopback detection of the default pattern
    kick(1'b1, 8'h00, 4'd4);
    run(45);
    chk("loop_hits", hits, 32'd4);

    for (int i = 0; i < 3000; i++) begin
      start       = ($urandom_range(0, 3) == 0);
      abort       = ($urandom_range(0, 39) == 0);
      use_default = $urandom_range(0, 1);
      pattern_in  = 8'($urandom);
      repeat_cnt  = 4'($urandom_range(0, 4));
      cycle();
    end
    start = 1'b0; abort = 1'b0;
    run(60);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
